rectangle_sched: RTL and testbench

- Shares one iterative RECTANGLE-80 round unit (64-bit block, 80-bit key, 25 rounds) between NREQ requesters.
- Round-robin arbitration; loads the winning plaintext/key into its own state/key registers.
- Sequences the 25 rounds, generating the round constant and count that drive the combinational round unit.
- Returns the whitened ciphertext with the requester ID over a valid/ready response port.

---
 rtl/rectangle_sched_if.sv | 25 ++
 rtl/rectangle_sched.sv | 119 +++++++++++
 tb/tb_rectangle_sched.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rectangle_sched_if.sv
// Request/response bundle for the shared RECTANGLE-80 scheduler.
// The master side holds the requesters and the result consumer; the slave side is the scheduler.
interface rectangle_sched_if #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IDW  = 1
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [64*NREQ-1:0] req_pt;
  logic [80*NREQ-1:0] req_key;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [63:0]        rsp_data;
  logic [IDW-1:0]     rsp_id;

  modport master (
    output req_valid, req_pt, req_key, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id
  );

  modport slave (
    input  req_valid, req_pt, req_key, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id
  );
endinterface

// File: rtl/rectangle_sched.sv
// Round-robin scheduler sharing one combinational RECTANGLE-80 round unit
// between NREQ requesters; sequences the rounds and returns the whitened result.
module rectangle_sched #(
  parameter int unsigned NREQ   = 2,
  parameter int unsigned IDW    = 1,
  parameter int unsigned ROUNDS = 25
) (
  input  logic                 clk,
  input  logic                 rst,
  rectangle_sched_if.slave     bus,
  output logic                 busy,
  output logic [63:0]          rf_state,
  output logic [79:0]          rf_key,
  output logic [4:0]           rf_rc,
  output logic [4:0]           rf_round,
  input  logic [63:0]          rf_state_nxt,
  input  logic [79:0]          rf_key_nxt
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  fsm_t           fsm;
  logic [63:0]    state_reg;
  logic [79:0]    key_reg;
  logic [4:0]     rc;
  logic [4:0]     cnt;
  logic [IDW-1:0] id_reg;
  logic [IDW-1:0] rr_ptr;
  logic           rsp_valid_q;
  logic           busy_q;

  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  gnt_id;
  logic [63:0]     gnt_pt;
  logic [79:0]     gnt_key;
  logic            found;

  // Offset i walks the ring starting just past the last winner; the first valid requester wins.
  always_comb begin
    grant   = '0;
    gnt_id  = '0;
    gnt_pt  = '0;
    gnt_key = '0;
    found   = 1'b0;
    if (fsm == IDLE) begin
      for (int unsigned i = 1; i <= NREQ; i++) begin
        for (int unsigned j = 0; j < NREQ; j++) begin
          if (!found && bus.req_valid[j] && (j == (32'(rr_ptr) + i) % NREQ)) begin
            found    = 1'b1;
            grant[j] = 1'b1;
            gnt_id   = IDW'(j);
            gnt_pt   = bus.req_pt[64*j +: 64];
            gnt_key  = bus.req_key[80*j +: 80];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm         <= IDLE;
      state_reg   <= '0;
      key_reg     <= '0;
      rc          <= 5'h01;
      cnt         <= '0;
      id_reg      <= '0;
      rr_ptr      <= IDW'(NREQ - 1);
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (fsm)
        IDLE: begin
          if (found) begin
            state_reg <= gnt_pt;
            key_reg   <= gnt_key;
            rc        <= 5'h01;
            cnt       <= '0;
            id_reg    <= gnt_id;
            rr_ptr    <= gnt_id;
            busy_q    <= 1'b1;
            fsm       <= RUN;
          end
        end
        RUN: begin
          state_reg <= rf_state_nxt;
          key_reg   <= rf_key_nxt;
          rc        <= {rc[3:0], rc[4] ^ rc[2]};
          if (cnt == 5'(ROUNDS - 1)) begin
            cnt         <= '0;
            rsp_valid_q <= 1'b1;
            fsm         <= DONE;
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
        DONE: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            fsm         <= IDLE;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = grant;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_valid_q ? (state_reg ^ key_reg[79:16]) : '0;
  assign bus.rsp_id    = rsp_valid_q ? id_reg : '0;
  assign busy          = busy_q;
  assign rf_state      = state_reg;
  assign rf_key        = key_reg;
  assign rf_rc         = rc;
  assign rf_round      = cnt;

endmodule

// File: tb/tb_rectangle_sched.sv
// Bench for rectangle_sched: supplies the RECTANGLE-80 round unit and checks every
// cycle against a transaction-level model that computes ciphertexts by direct encryption.
module tb_rectangle_sched;
  localparam int unsigned NREQ   = 2;
  localparam int unsigned IDW    = 1;
  localparam int unsigned ROUNDS = 25;

  localparam logic [3:0] SBOX [16] = '{4'h6, 4'h5, 4'hC, 4'hA, 4'h1, 4'hE, 4'h7, 4'h9,
                                       4'hB, 4'h0, 4'h3, 4'hD, 4'h8, 4'hF, 4'h4, 4'h2};
  localparam logic [4:0] RC_TAB [25] = '{5'h01, 5'h02, 5'h04, 5'h09, 5'h12, 5'h05, 5'h0B,
                                         5'h16, 5'h0C, 5'h19, 5'h13, 5'h07, 5'h0F, 5'h1F,
                                         5'h1E, 5'h1C, 5'h18, 5'h11, 5'h03, 5'h06, 5'h0D,
                                         5'h1B, 5'h17, 5'h0E, 5'h1D};

  logic        clk = 1'b0;
  logic        rst;
  logic        busy;
  logic [63:0] rf_state, rf_state_nxt;
  logic [79:0] rf_key, rf_key_nxt;
  logic [4:0]  rf_rc, rf_round;

  rectangle_sched_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  rectangle_sched #(.NREQ(NREQ), .IDW(IDW), .ROUNDS(ROUNDS)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .busy         (busy),
    .rf_state     (rf_state),
    .rf_key       (rf_key),
    .rf_rc        (rf_rc),
    .rf_round     (rf_round),
    .rf_state_nxt (rf_state_nxt),
    .rf_key_nxt   (rf_key_nxt)
  );

  always #5 clk = ~clk;

  // ---------------- RECTANGLE-80 reference ----------------
  function automatic logic [15:0] rol16(input logic [15:0] x, input int unsigned n);
    return (x << n) | (x >> (16 - n));
  endfunction

  function automatic logic [63:0] rect_round(input logic [63:0] s, input logic [79:0] k);
    logic [63:0] t;
    logic [15:0] a0, a1, a2, a3, b0, b1, b2, b3;
    logic [3:0]  o;
    t  = s ^ k[79:16];
    a0 = t[63:48]; a1 = t[47:32]; a2 = t[31:16]; a3 = t[15:0];
    b0 = '0; b1 = '0; b2 = '0; b3 = '0;
    for (int j = 0; j < 16; j++) begin
      o = SBOX[{a3[j], a2[j], a1[j], a0[j]}];
      b0[j] = o[0]; b1[j] = o[1]; b2[j] = o[2]; b3[j] = o[3];
    end
    return {b0, rol16(b1, 1), rol16(b2, 12), rol16(b3, 13)};
  endfunction

  function automatic logic [79:0] rect_ks(input logic [79:0] k, input logic [4:0] rcv);
    logic [15:0] k0, k1, k2, k3, k4, n0;
    logic [3:0]  o;
    k0 = k[79:64]; k1 = k[63:48]; k2 = k[47:32]; k3 = k[31:16]; k4 = k[15:0];
    for (int j = 0; j < 4; j++) begin
      o = SBOX[{k3[j], k2[j], k1[j], k0[j]}];
      k0[j] = o[0]; k1[j] = o[1]; k2[j] = o[2]; k3[j] = o[3];
    end
    n0 = rol16(k0, 8) ^ k1;
    n0[4:0] = n0[4:0] ^ rcv;
    return {n0, k2, k3, rol16(k3, 12) ^ k4, k0};
  endfunction

  function automatic logic [63:0] encrypt(input logic [63:0] pt, input logic [79:0] key);
    logic [63:0] s;
    logic [79:0] k;
    s = pt; k = key;
    for (int i = 0; i < ROUNDS; i++) begin
      s = rect_round(s, k);
      k = rect_ks(k, RC_TAB[i]);
    end
    return s ^ k[79:16];
  endfunction

  always_comb begin
    rf_state_nxt = rect_round(rf_state, rf_key);
    rf_key_nxt   = rect_ks(rf_key, rf_rc);
  end

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [79:0] got, input logic [79:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  // Transaction-level model: job in flight, rounds elapsed, last winner.
  bit          m_busy, m_fresh;
  int unsigned m_cnt, m_last, m_id;
  logic [63:0] m_pt, m_ct;
  logic [79:0] m_key;
  int          grant_q[$];
  int          rsp_q[$];

  task automatic model_reset();
    m_busy = 1'b0; m_fresh = 1'b1; m_cnt = 0; m_last = NREQ - 1; m_id = 0;
  endtask

  task automatic compare_cycle();
    logic [NREQ-1:0] exp_ready;
    int   w;
    bit   run, dv;
    int unsigned r;
    exp_ready = '0;
    w = -1;
    if (!m_busy)
      for (int unsigned i = 1; i <= NREQ; i++) begin
        r = (m_last + i) % NREQ;
        if (w < 0 && bus.req_valid[r]) w = int'(r);
      end
    if (w >= 0) exp_ready[w] = 1'b1;
    run = m_busy && (m_cnt < ROUNDS);
    dv  = m_busy && (m_cnt == ROUNDS);

    check("req_ready", bus.req_ready, exp_ready);
    check("busy", busy, m_busy);
    check("rsp_valid", bus.rsp_valid, dv);
    check("rsp_data", bus.rsp_data, dv ? m_ct : 64'h0);
    check("rsp_id", bus.rsp_id, dv ? m_id : 0);
    check("rf_round", rf_round, run ? m_cnt : 0);
    if (run) check("rf_rc", rf_rc, RC_TAB[m_cnt]);
    if (run && m_cnt == 0) begin
      check("rf_state_load", rf_state, m_pt);
      check("rf_key_load", rf_key, m_key);
    end
    if (m_fresh && !m_busy) begin
      check("rf_state_rst", rf_state, 64'h0);
      check("rf_key_rst", rf_key, 80'h0);
      check("rf_rc_rst", rf_rc, 5'h01);
    end

    if (!rst) begin
      for (int k = 0; k < NREQ; k++)
        if (bus.req_valid[k] && bus.req_ready[k]) grant_q.push_back(k);
      if (bus.rsp_valid && bus.rsp_ready) rsp_q.push_back(int'(bus.rsp_id));
    end

    if (rst) model_reset();
    else if (!m_busy) begin
      if (w >= 0) begin
        m_busy = 1'b1; m_fresh = 1'b0; m_cnt = 0; m_id = w; m_last = w;
        m_pt  = bus.req_pt[64*w +: 64];
        m_key = bus.req_key[80*w +: 80];
        m_ct  = encrypt(m_pt, m_key);
      end
    end else if (m_cnt < ROUNDS) m_cnt++;
    else if (bus.rsp_ready) m_busy = 1'b0;
  endtask

  initial begin : compare
    @(posedge clk);
    model_reset();
    forever begin
      @(negedge clk);
      compare_cycle();
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_req(input int r, input logic v, input logic [63:0] pt, input logic [79:0] key);
    bus.req_pt[64*r +: 64]  = pt;
    bus.req_key[80*r +: 80] = key;
    bus.req_valid[r]        = v;
  endtask

  task automatic wait_accept(input int r);
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (bus.req_ready[r]) begin
        @(posedge clk); #1;
        bus.req_valid[r] = 1'b0;
        return;
      end
    end
    check("accept_timeout", 1, 0);
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 400; n++) begin
      @(posedge clk); #1;
      if (!busy && !bus.rsp_valid) return;
    end
    check("idle_timeout", 1, 0);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  function automatic logic [79:0] rnd_key();
    return {16'($urandom), $urandom, $urandom};
  endfunction

  initial begin : stim
    int lat, base, rbase, g, acc_n, started, cyc;
    logic [63:0] pt;
    logic [79:0] key;
    logic [NREQ-1:0] acc;
    bit hit;

    rst = 1'b1;
    bus.req_valid = '0; bus.req_pt = '0; bus.req_key = '0; bus.rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // single request, all-zero operands
    bus.rsp_ready = 1'b1;
    set_req(0, 1'b1, 64'h0, 80'h0);
    wait_accept(0);
    lat = 0;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      if (bus.rsp_valid) begin lat = n; break; end
    end
    check("latency", lat, 25);
    check("single_id", bus.rsp_id, 0);
    check("single_data", bus.rsp_data, encrypt(64'h0, 80'h0));
    wait_idle();

    // two requesters held valid: grants alternate starting from 0
    pulse_reset();
    base = grant_q.size(); rbase = rsp_q.size();
    set_req(0, 1'b1, 64'h0123_4567_89AB_CDEF, 80'h1111_2222_3333_4444_5555);
    set_req(1, 1'b1, 64'hFEDC_BA98_7654_3210, 80'hAAAA_BBBB_CCCC_DDDD_EEEE);
    for (int n = 0; n < 400; n++) begin
      @(posedge clk); #1;
      if (grant_q.size() >= base + 4) break;
    end
    bus.req_valid = '0;
    wait_idle();
    check("rr_count", grant_q.size() - base, 4);
    check("rr_g0", grant_q[base],     0);
    check("rr_g1", grant_q[base + 1], 1);
    check("rr_g2", grant_q[base + 2], 0);
    check("rr_g3", grant_q[base + 3], 1);
    for (int i = 0; i < 4; i++) check("rr_rsp_id", rsp_q[rbase + i], i % 2);

    // back-pressure with a competing request waiting
    bus.rsp_ready = 1'b0;
    pt = {$urandom, $urandom}; key = rnd_key();
    set_req(0, 1'b1, pt, key);
    wait_accept(0);
    set_req(1, 1'b1, 64'h5A5A_5A5A_A5A5_A5A5, rnd_key());
    hit = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(posedge clk); #1;
      if (bus.rsp_valid) begin hit = 1'b1; break; end
    end
    check("bp_valid_seen", hit, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    check("bp_valid_held", bus.rsp_valid, 1'b1);
    check("bp_data_held", bus.rsp_data, encrypt(pt, key));
    check("bp_ready_zero", bus.req_ready, 0);
    bus.rsp_ready = 1'b1;
    wait_accept(1);
    wait_idle();
    check("bp_next_grant", grant_q[grant_q.size() - 1], 1);

    // reset during round 12 aborts the job silently
    set_req(0, 1'b1, {$urandom, $urandom}, rnd_key());
    wait_accept(0);
    hit = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(posedge clk); #1;
      if (rf_round == 5'd12) begin hit = 1'b1; break; end
    end
    check("abort_round_seen", hit, 1'b1);
    rbase = rsp_q.size();
    pulse_reset();
    check("abort_busy", busy, 1'b0);
    repeat (40) @(posedge clk);
    #1;
    check("abort_no_rsp", rsp_q.size() - rbase, 0);
    set_req(0, 1'b1, '1, '1);
    wait_accept(0);
    wait_idle();
    check("ones_rsp_count", rsp_q.size() - rbase, 1);

    // requester 1 withdraws its request while the unit is busy
    set_req(0, 1'b1, {$urandom, $urandom}, rnd_key());
    wait_accept(0);
    g = grant_q.size();
    repeat (3) @(posedge clk);
    #1 set_req(1, 1'b1, {$urandom, $urandom}, rnd_key());
    repeat (5) @(posedge clk);
    #1 bus.req_valid[1] = 1'b0;
    wait_idle();
    check("withdraw_grants", grant_q.size() - g, 0);
    check("withdraw_last", grant_q[grant_q.size() - 1], 0);

    // random jobs, random requesters, random consumer stalls
    rbase = rsp_q.size();
    acc_n = 0; started = 0; cyc = 0;
    while (!(acc_n == 200 && rsp_q.size() == rbase + 200) && cyc < 30000) begin
      @(negedge clk);
      acc = bus.req_valid & bus.req_ready;
      @(posedge clk); #1;
      cyc++;
      bus.rsp_ready = 1'($urandom_range(0, 1));
      for (int r = 0; r < NREQ; r++) begin
        if (acc[r]) begin
          bus.req_valid[r] = 1'b0;
          acc_n++;
        end else if (bus.req_valid[r] && $urandom_range(0, 39) == 0) begin
          bus.req_valid[r] = 1'b0;
          started--;
        end
        if (!bus.req_valid[r] && started < 200 && $urandom_range(0, 3) == 0) begin
          set_req(r, 1'b1, {$urandom, $urandom}, rnd_key());
          started++;
        end
      end
    end
    check("rand_accepts", acc_n, 200);
    check("rand_rsp_count", rsp_q.size() - rbase, 200);
    bus.rsp_ready = 1'b1;
    wait_idle();
    check("lost_or_dup", grant_q.size() - rsp_q.size(), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
